// File: rtl/keypad_scan.sv
// 3x4 matrix keypad scanner with frame debounce, priority encode and trigger levels.
// Latency: 2-cycle row sync, then DEBOUNCE_FRAMES matching frames plus 1 output register; no backpressure.
module keypad_scan #(
   parameter int unsigned SCAN_DIV        = 16,
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   output logic [2:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_press,
   output logic       key0,
   output logic       key8,
   output logic       key_star
);

   localparam logic [15:0] DWELL_MAX = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  DEB_MAX   = 4'(DEBOUNCE_FRAMES);

   // Bit positions in the key vectors equal the key code, so the encoder is a plain lowest-bit search.
   function automatic logic [3:0] key_of(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'd0;
      if (row != 2'd3) begin
         code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
      end else begin
         case (col)
            2'd0:    code = 4'd10;
            2'd1:    code = 4'd0;
            default: code = 4'd11;
         endcase
      end
      return code;
   endfunction

   logic [3:0]  r_row_meta;
   logic [3:0]  r_row_sync;
   logic [15:0] r_dwell;
   logic [1:0]  r_col;
   logic [2:0]  r_col_n;
   logic [11:0] r_raw;
   logic [11:0] r_prev;
   logic [11:0] r_deb;
   logic [3:0]  r_stable;
   logic        r_press_pend;
   logic [3:0]  r_key_code;
   logic        r_key_valid;
   logic        r_key_press;
   logic        r_key0;
   logic        r_key8;
   logic        r_key_star;

   logic        w_wrap;
   logic        w_frame_end;
   logic [11:0] w_hit;
   logic [11:0] w_raw_frame;
   logic [3:0]  w_stable_next;
   logic        w_load;
   logic [3:0]  w_enc;
   logic [1:0]  w_col_next;

   always_comb begin
      w_wrap      = (r_dwell == DWELL_MAX);
      w_frame_end = w_wrap && (r_col == 2'd2);
      w_col_next  = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;

      w_hit = '0;
      for (int r = 0; r < 4; r++) begin
         if (!r_row_sync[r]) w_hit[key_of(2'(r), r_col)] = 1'b1;
      end
      w_raw_frame = w_wrap ? (r_raw | w_hit) : r_raw;

      // After reset r_prev is empty, so the first frame always leaves the counter at 1.
      if (w_raw_frame == r_prev)
         w_stable_next = (r_stable >= DEB_MAX) ? DEB_MAX : r_stable + 4'd1;
      else
         w_stable_next = 4'd1;
      w_load = w_frame_end && (w_stable_next == DEB_MAX);

      w_enc = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (r_deb[i]) w_enc = 4'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_meta   <= 4'hF;
         r_row_sync   <= 4'hF;
         r_dwell      <= '0;
         r_col        <= 2'd0;
         r_col_n      <= 3'b110;
         r_raw        <= '0;
         r_prev       <= '0;
         r_deb        <= '0;
         r_stable     <= '0;
         r_press_pend <= 1'b0;
      end else begin
         r_row_meta <= row_n;
         r_row_sync <= r_row_meta;

         if (w_wrap) begin
            r_dwell <= '0;
            r_col   <= w_col_next;
            case (w_col_next)
               2'd0:    r_col_n <= 3'b110;
               2'd1:    r_col_n <= 3'b101;
               default: r_col_n <= 3'b011;
            endcase
         end else begin
            r_dwell <= r_dwell + 16'd1;
         end

         if (w_frame_end) begin
            r_raw    <= '0;
            r_prev   <= w_raw_frame;
            r_stable <= w_stable_next;
            if (w_load) r_deb <= w_raw_frame;
         end else if (w_wrap) begin
            r_raw <= w_raw_frame;
         end

         r_press_pend <= w_load && |(w_raw_frame & ~r_deb);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_press <= 1'b0;
         r_key0      <= 1'b0;
         r_key8      <= 1'b0;
         r_key_star  <= 1'b0;
      end else begin
         r_key_code  <= w_enc;
         r_key_valid <= |r_deb;
         r_key_press <= r_press_pend;
         r_key0      <= r_deb[0];
         r_key8      <= r_deb[8];
         r_key_star  <= r_deb[10];
      end
   end

   assign col_n     = r_col_n;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_press = r_key_press;
   assign key0      = r_key0;
   assign key8      = r_key8;
   assign key_star  = r_key_star;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model closes rows onto driven columns; table plus corner sequences.
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] mask, mask1;

   logic [3:0] row_n, row_n1;
   logic [2:0] col_n, col_n1;
   logic [3:0] key_code, key_code1;
   logic       key_valid, key_press, key0, key8, key_star;
   logic       key_valid1, key_press1, key0_1, key8_1, key_star1;

   always #5 clk = ~clk;

   function automatic int key_idx(input int ro, input int c);
      if (ro < 3) return ro * 3 + c + 1;
      if (c == 0) return 10;
      if (c == 1) return 0;
      return 11;
   endfunction

   function automatic logic [3:0] kp_rows(input logic [11:0] m, input logic [2:0] cn);
      logic [3:0] r;
      r = 4'hF;
      for (int ro = 0; ro < 4; ro++)
         for (int c = 0; c < 3; c++)
            if (!cn[c] && m[key_idx(ro, c)]) r[ro] = 1'b0;
      return r;
   endfunction

   assign row_n  = kp_rows(mask, col_n);
   assign row_n1 = kp_rows(mask1, col_n1);

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
      .key_code(key_code), .key_valid(key_valid), .key_press(key_press),
      .key0(key0), .key8(key8), .key_star(key_star));

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .row_n(row_n1), .col_n(col_n1),
      .key_code(key_code1), .key_valid(key_valid1), .key_press(key_press1),
      .key0(key0_1), .key8(key8_1), .key_star(key_star1));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int press_cnt, press_cnt1;
   logic seen_star, seen_valid;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] exp_col(input int c);
      case ((c / 4) % 3)
         0:       return 3'b110;
         1:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      chk("col_n", int'(col_n), int'(exp_col(cyc)));
      chk("col_n dfr1", int'(col_n1), int'(exp_col(cyc)));
      press_cnt  += int'(key_press);
      press_cnt1 += int'(key_press1);
      seen_star  |= key_star;
      seen_valid |= key_valid;
   endtask

   typedef struct {
      logic [11:0] mask;
      logic [3:0]  code;
      logic        valid, k0, k8, kstar;
      int          presses;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{12'h000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1] = '{12'h100, 4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1};
      vecs[2] = '{12'h000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[3] = '{12'h401, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1};
      vecs[4] = '{12'h400, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, 0};
      vecs[5] = '{12'hC00, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      vecs[6] = '{12'h222, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[7] = '{12'h800, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[8] = '{12'h101, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1};

      rst_n = 1'b0; mask = '0; mask1 = '0;
      press_cnt = 0; press_cnt1 = 0; seen_star = 1'b0; seen_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst col_n", int'(col_n), 3'b110);
      chk("rst key_code", int'(key_code), 0);
      chk("rst key_valid", int'(key_valid), 0);
      chk("rst key_press", int'(key_press), 0);
      chk("rst key0/8/star", int'({key0, key8, key_star}), 0);

      rst_n = 1'b1; cyc = 0;
      foreach (vecs[i]) begin
         mask = vecs[i].mask;
         press_cnt = 0;
         repeat (36) step();
         chk($sformatf("vec%0d key_code", i), int'(key_code), int'(vecs[i].code));
         chk($sformatf("vec%0d key_valid", i), int'(key_valid), int'(vecs[i].valid));
         chk($sformatf("vec%0d key0", i), int'(key0), int'(vecs[i].k0));
         chk($sformatf("vec%0d key8", i), int'(key8), int'(vecs[i].k8));
         chk($sformatf("vec%0d key_star", i), int'(key_star), int'(vecs[i].kstar));
         chk($sformatf("vec%0d presses", i), press_cnt, vecs[i].presses);
      end

      // Mid-frame reset while '0' is held.
      mask = 12'h001;
      repeat (36) step();
      chk("hold0 key0", int'(key0), 1);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("midrst col_n", int'(col_n), 3'b110);
      chk("midrst outs", int'({key_code, key_valid, key_press, key0, key8, key_star}), 0);
      @(negedge clk);
      @(negedge clk);
      chk("midrst held key0", int'(key0), 0);
      mask1 = 12'h800;
      rst_n = 1'b1; cyc = 0; press_cnt = 0; press_cnt1 = 0;
      repeat (36) begin
         step();
         if (cyc == 12) chk("dfr1 code early", int'(key_code1), 0);
         if (cyc == 13) chk("dfr1 code #", int'(key_code1), 11);
         if (cyc == 24) chk("post-rst key0 early", int'(key0), 0);
         if (cyc == 25) chk("post-rst key0", int'(key0), 1);
      end
      chk("post-rst presses", press_cnt, 1);
      chk("dfr1 presses", press_cnt1, 1);

      // One-frame glitch on '*' must never reach the outputs.
      mask = '0;
      repeat (36) step();
      chk("pre-glitch key_valid", int'(key_valid), 0);
      press_cnt = 0; seen_star = 1'b0; seen_valid = 1'b0;
      mask = 12'h400;
      repeat (12) step();
      mask = '0;
      repeat (36) step();
      chk("glitch key_star", int'(seen_star), 0);
      chk("glitch key_valid", int'(seen_valid), 0);
      chk("glitch presses", press_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 16, meaning clock cycles each column is driven (legal range 4..65535).
REQ-002 SHALL provide parameter DEBOUNCE_FRAMES, default 4, meaning consecutive identical scan frames needed to accept a key state (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port row_n, input, 4, keypad rows: active-low, pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n, output, 3, keypad column drive: active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_code, output, 4, code of the selected debounced key: digits 0-9 give 0-9, '*' gives 10, '#' gives 11.
REQ-008 SHALL have port key_valid, output, 1, high while at least one debounced key is pressed.
REQ-009 SHALL have port key_press, output, 1, one-cycle pulse when a newly pressed key is accepted.
REQ-010 SHALL have ports key0, key8 and key_star, output, 1 each, debounced levels for keys '0', '8' and '*'; these feed the game's trigger inputs.

Function
REQ-011 Keypad map SHALL be: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#; in each row, col0..col2 are listed left to right.
REQ-012 row_n SHALL pass through a 2-flop synchronizer before use; this gives 2 cycles of latency.
REQ-013 Dwell counter SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-014 At each wrap, col_n SHALL rotate col0 -> col1 -> col2 -> col0; col_n = 3'b110 means col0 is driven.
REQ-015 Synchronized rows SHALL be sampled only on the cycle with dwell count = SCAN_DIV-1, giving settle time for drive and synchronizer.
REQ-016 A sampled row bit that reads low SHALL set the bit in a 12-bit raw vector for the key at that row and the currently driven column.
REQ-017 A frame SHALL end at the col2 sample, so one frame lasts 3*SCAN_DIV cycles.
REQ-018 At frame end, if the raw vector equals the previous frame's raw vector, the stable counter SHALL increment, saturating at DEBOUNCE_FRAMES.
REQ-019 At frame end, if the raw vector differs from the previous frame's raw vector, the stable counter SHALL reset to 1.
REQ-020 When the stable counter reaches DEBOUNCE_FRAMES, the raw vector SHALL be loaded into the debounced vector in that same cycle.
REQ-021 All outputs SHALL be registered and SHALL update 1 cycle after the debounced vector is loaded.
REQ-022 key_code SHALL come from a priority encoder that selects the lowest code among pressed keys; key_code SHALL be 0 when no key is pressed.
REQ-023 key_press SHALL pulse for exactly 1 cycle when the new debounced vector contains any bit that the old vector did not contain.
REQ-024 key_press SHALL NOT pulse on a key release.
REQ-025 key_press SHALL NOT pulse when the debounced vector is reloaded with an unchanged value.
REQ-026 Multiple simultaneous keys SHALL all be reflected in key0, key8 and key_star independently; ghosting is not suppressed.
REQ-027 A glitch shorter than DEBOUNCE_FRAMES frames SHALL never reach any output.
REQ-028 Before the first accepted frame after reset, no raw comparison SHALL take place; the previous-raw register resets to all-zero, meaning no keys.

Reset
REQ-029 While rst_n = 0, the block SHALL hold: col_n = 3'b110; dwell = 0; all raw, previous and debounced vectors = 0; stable counter = 0; key_code = 0; key_valid = 0; key_press = 0; key0 = key8 = key_star = 0.
REQ-030 Assertion of rst_n mid-frame SHALL take effect immediately and discard any partial frame.
REQ-031 Scanning SHALL restart with col0 on the first clk edge after rst_n deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2 unless stated)
REQ-032 Hold '8' (row2 low while col1 is driven) -> key8 = 1, key_code = 8, key_valid = 1, and one key_press pulse, all within 2 frames + 3 cycles; key0 = key_star = 0.
REQ-033 Pulse row3 low for one frame while '*' is driven -> key_star, key_valid and key_press all stay 0.
REQ-034 Hold '*' and '0' together -> key_star = 1, key0 = 1, key_code = 0, one key_press; release '0' only -> key0 = 0, key_code = 10, no key_press.
REQ-035 Assert rst_n = 0 mid-frame while '0' is held -> all outputs 0 and col_n = 3'b110 at once; after release, key0 is reasserted after 2 full frames.
REQ-036 Check col_n every cycle -> exactly one bit low, the pattern advances every 4 cycles, and the sequence 110, 101, 011 repeats.
REQ-037 Run with DEBOUNCE_FRAMES=1 and press '#' -> key_code = 11 after 1 frame + 3 cycles, with a single key_press pulse.
